// File: rtl/regfile_dump_if.sv
// regfile_dump_if: valid/ready stream carrying one register value tagged with its address
interface regfile_dump_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_valid;
   logic              out_ready;
   modport master (output out_data, out_addr, out_valid, input out_ready);
   modport slave (input out_data, out_addr, out_valid, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: walks a wrapping address range on one register-file read port and streams (addr, data) entries
module regfile_dump #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     first_addr,
   input  logic [ADDR_W-1:0]     last_addr,
   output logic [ADDR_W-1:0]     rf_addr,
   input  logic [DATA_W-1:0]     rf_data,
   regfile_dump_if.master        out,
   output logic                  busy,
   output logic                  done
);
   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
   state_t state, nxt;
   logic [ADDR_W-1:0] cur_addr, end_addr;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cur_addr     <= '0;
         end_addr     <= '0;
         out.out_data <= '0;
         out.out_addr <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) begin
            cur_addr <= first_addr;
            end_addr <= last_addr;
         end
         if (state == READ) begin
            out.out_data <= rf_data;
            out.out_addr <= cur_addr;
         end
         // address wraps naturally at 2^ADDR_W
         if (state == SEND && out.out_ready && cur_addr != end_addr)
            cur_addr <= cur_addr + 1'b1;
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? READ : IDLE;
         READ:    nxt = SEND;
         SEND:    nxt = !out.out_ready ? SEND : (cur_addr == end_addr ? DONE : READ);
         default: nxt = IDLE;
      endcase
   end
   assign rf_addr       = cur_addr;
   assign out.out_valid = state == SEND;
   assign busy          = state == READ || state == SEND;
   assign done          = state == DONE;
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard bench; expected entries are derived from the range rules and a register-file array
module tb_regfile_dump;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] first_addr = '0;
   logic [2:0] last_addr = '0;
   logic [2:0] rf_addr;
   logic [7:0] rf_data;
   logic       busy, done;
   logic [7:0] rf [8];

   regfile_dump_if #(.ADDR_W(3), .DATA_W(8)) dif ();

   regfile_dump #(.ADDR_W(3), .DATA_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .first_addr(first_addr), .last_addr(last_addr),
      .rf_addr(rf_addr), .rf_data(rf_data), .out(dif.master),
      .busy(busy), .done(done)
   );

   assign rf_data = rf[rf_addr];
   always #5 clk = ~clk;

   typedef struct packed {logic [2:0] a; logic [7:0] d;} ent_t;
   ent_t exp_q[$];
   int compared = 0, mismatched = 0;
   int busy_cnt = 0, done_cnt = 0, stall_cnt = 0, mode = 0, bp_cnt = 0;
   bit snap_en = 0, held_v = 0;
   ent_t held;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard on every handshake and checks hold stability under backpressure
   always @(negedge clk) begin
      if (reset_n) begin
         busy_cnt += int'(busy);
         done_cnt += int'(done);
         if (dif.out_valid) begin
            if (held_v) begin
               chk("hold_addr", int'(dif.out_addr), int'(held.a));
               chk("hold_data", int'(dif.out_data), int'(held.d));
            end
            if (dif.out_ready) begin
               if (exp_q.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_entry: got addr %0d data 0x%0h, none expected", dif.out_addr, dif.out_data);
               end else begin
                  ent_t e;
                  e = exp_q.pop_front();
                  chk("entry_addr", int'(dif.out_addr), int'(e.a));
                  chk("entry_data", int'(dif.out_data), int'(e.d));
               end
               held_v = 0;
            end else begin
               held_v = 1;
               held = '{a: dif.out_addr, d: dif.out_data};
               stall_cnt++;
            end
         end else
            held_v = 0;
      end
   end

   // consumer and register-file writer, updated just after each rising edge
   always @(posedge clk) begin
      #1;
      if (snap_en && dif.out_valid && dif.out_addr == 3'd2) begin
         rf[2] = 8'h55;
         snap_en = 0;
      end
      if (mode == 0)
         dif.out_ready = 1'b1;
      else if (mode == 1)
         dif.out_ready = 1'($urandom_range(0, 1));
      else if (dif.out_valid && dif.out_addr == 3'd3 && bp_cnt < 5) begin
         dif.out_ready = 1'b0;
         bp_cnt++;
      end else
         dif.out_ready = 1'b1;
   end

   task automatic push_range(input logic [2:0] f, input logic [2:0] l);
      int n;
      n = ((int'(l) - int'(f)) & 7) + 1;
      for (int i = 0; i < n; i++) begin
         logic [2:0] a;
         a = 3'((int'(f) + i) % 8);
         exp_q.push_back('{a: a, d: rf[a]});
      end
   endtask

   task automatic issue_start(input logic [2:0] f, input logic [2:0] l, input bit extra_start);
      @(posedge clk);
      #1 first_addr = f; last_addr = l; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      first_addr = 3'($urandom);
      last_addr = 3'($urandom);
      if (extra_start) begin
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
   endtask

   task automatic run_dump(input logic [2:0] f, input logic [2:0] l, input int m, input bit extra_start);
      int d0;
      push_range(f, l);
      mode = m;
      bp_cnt = 0;
      busy_cnt = 0;
      stall_cnt = 0;
      d0 = done_cnt;
      issue_start(f, l, extra_start);
      for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
      if (done_cnt == d0) begin
         compared++;
         mismatched++;
         $display("FAIL done_timeout: no done within 300 cycles for range %0d..%0d", f, l);
      end
      repeat (3) @(negedge clk);
      chk("done_pulses", done_cnt - d0, 1);
      chk("queue_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int d0;
      for (int i = 0; i < 8; i++) rf[i] = 8'hAA + 8'(i);
      dif.out_ready = 1'b1;
      #1;
      chk("rst_rf_addr", int'(rf_addr), 0);
      chk("rst_out_data", int'(dif.out_data), 0);
      chk("rst_out_addr", int'(dif.out_addr), 0);
      chk("rst_out_valid", int'(dif.out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      #20 reset_n = 1'b1;

      run_dump(3'd0, 3'd7, 0, 0);
      chk("full_busy_cycles", busy_cnt, 16);
      run_dump(3'd6, 3'd1, 0, 0);
      run_dump(3'd3, 3'd3, 0, 1);
      chk("single_busy_cycles", busy_cnt, 2);
      run_dump(3'd2, 3'd4, 2, 0);
      chk("bp_stall_cycles", stall_cnt, 5);
      snap_en = 1;
      run_dump(3'd0, 3'd3, 0, 0);
      chk("snap_write_done", int'(snap_en), 0);
      run_dump(3'd2, 3'd2, 0, 0);

      // abort a full dump during entry 5 with an asynchronous reset
      push_range(3'd0, 3'd7);
      mode = 0;
      issue_start(3'd0, 3'd7, 0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (dif.out_valid && dif.out_addr == 3'd5) break;
      end
      chk("abort_reached_entry5", int'(dif.out_addr), 5);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_rf_addr", int'(rf_addr), 0);
      chk("abort_out_data", int'(dif.out_data), 0);
      chk("abort_out_addr", int'(dif.out_addr), 0);
      chk("abort_out_valid", int'(dif.out_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      exp_q.delete();
      held_v = 0;
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_idle_busy", int'(busy), 0);
      chk("abort_idle_valid", int'(dif.out_valid), 0);
      run_dump(3'd4, 3'd6, 0, 0);

      for (int k = 0; k < 20; k++) run_dump(3'($urandom), 3'($urandom), 1, 1'($urandom_range(0, 1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
